simd_wave_ctrl: RTL and testbench
=================================

// Module: simd_wave_ctrl
// PURPOSE
//  Per-SIMD wave sequencer, the receiving end of the wave dispatch handshake.
//  Accepts a wave (simd_start + wave_id) and builds the lane mask and thread base.
//  Runs the fetch/issue loop on the lane datapath until a RET instruction.
//  Then pulses simd_done back to the dispatcher. One instance per SIMD in a compute unit.
// PARAMETERS
//  WAVE_SIZE    32      lanes per wave (mask width)
//  PC_WIDTH     8       instruction address width
//  INSTR_WIDTH  16      instruction width; opcode = instr[INSTR_WIDTH-1 -: 4]
//  OPC_RET      4'hF    opcode that terminates the wave
//  START_PC     0       PC loaded on every accepted start
// PORTS
//  clk               in   1            clock, all state updates on rising edge
//  rst_n             in   1            asynchronous active-low reset
//  simd_start        in   1            dispatcher: new wave assigned this cycle
//  wave_id           in   32 signed    wave index within block; -1 = invalid
//  core_block_id     in   32 signed    block currently held by this CU
//  block_dim         in   32           threads per block (kernel metadata)
//  num_threads       in   32           total kernel threads
//  simd_done         out  1            one-cycle pulse: wave finished
//  busy              out  1            high in every state except IDLE
//  imem_req          out  1            instruction fetch request
//  imem_addr         out  PC_WIDTH     fetch address (= pc)
//  imem_valid        in   1            fetch data valid
//  imem_data         in   INSTR_WIDTH  fetched instruction
//  lane_issue        out  1            one-cycle pulse: lanes execute lane_instr
//  lane_instr        out  INSTR_WIDTH  instruction to lanes
//  lane_mask         out  WAVE_SIZE    active lanes, bit i = lane i
//  lane_thread_base  out  32           global thread id of lane 0
//  lane_done         in   1            lanes finished the issued instruction
// BEHAVIOUR
//  - All outputs are registered. Reset values are 0 for simd_done, busy, imem_req, imem_addr,
//    lane_issue, lane_instr, lane_mask and lane_thread_base; state resets to IDLE and pc to START_PC.
//  - Reset is asynchronous and may be asserted mid-wave. It aborts the wave and produces no simd_done.
//  - States:
//    - IDLE: start is accepted when simd_start=1 and wave_id>=0.
//      - base  = core_block_id*block_dim + wave_id*WAVE_SIZE (32-bit, wraps modulo 2^32).
//      - Latch lane_thread_base = base.
//      - Lane i is active iff (wave_id*WAVE_SIZE+i) < block_dim AND (base+i) < num_threads.
//      - pc <= START_PC.
//      - If the mask is all-zero, go to DONE; otherwise go to FETCH.
//      - simd_start with wave_id<0 is ignored and the block stays in IDLE.
//    - FETCH: imem_req=1 and imem_addr=pc, held until imem_valid=1 is sampled.
//      - imem_valid may arrive in the first FETCH cycle.
//      - On valid, latch the instruction into lane_instr and drop imem_req next cycle.
//      - If opcode==OPC_RET, go to DONE; otherwise go to ISSUE.
//    - ISSUE: lane_issue=1 for exactly one cycle, then WAIT_LANES.
//      - lane_done is ignored while in ISSUE.
//    - WAIT_LANES: on lane_done, pc <= pc+1 (wraps at 2^PC_WIDTH) and go to FETCH.
//    - DONE: simd_done=1 for exactly one cycle, then IDLE. busy drops on the same edge.
//  - simd_start while busy (including in DONE) is ignored. The wave in flight is unaffected.
//  - Minimum start-to-done latency is 3 cycles with an immediate RET:
//    - edge0: start sampled -> FETCH
//    - edge1: valid -> DONE
//    - edge2: simd_done high
//  - Empty-mask wave: simd_done is high 2 edges after start. No fetch and no lane_issue occur.
//  - imem_data and lane_done are don't-care outside FETCH and WAIT_LANES respectively.
// TESTING
//  1. Full wave, immediate RET:
//     - Stimulus: block_dim=64, num_threads=128, block 1, wave_id=1, imem returns RET same cycle.
//     - Required: lane_thread_base=96, mask=0xFFFFFFFF, no lane_issue, single simd_done pulse.
//  2. Partial last wave:
//     - Stimulus: num_threads=100, block_dim=64, block 1, wave 1.
//     - Required: base=96, mask=0x0000000F.
//  3. Three-instruction program (ADD, ADD, RET) with 2-cycle imem latency and 3-cycle lane_done:
//     - Required: imem_addr sequence 0,1,2; exactly two lane_issue pulses; one simd_done.
//  4. Empty wave:
//     - Stimulus: num_threads=96, block 1, block_dim=64, wave 1 (base=96).
//     - Required: mask=0, simd_done 2 edges after start, imem_req never asserted.
//  5. Protocol robustness:
//     - simd_start pulse in WAIT_LANES: ignored, lane_thread_base unchanged.
//     - wave_id=-1 in IDLE: stays IDLE.
//     - lane_done held high through ISSUE: ignored until WAIT_LANES.
//  6. Reset mid-wave:
//     - Stimulus: drop rst_n asynchronously in WAIT_LANES.
//     - Required: outputs 0 immediately, no simd_done; next start runs from START_PC.

Source files
------------

// File: rtl/simd_wave_ctrl.sv
// Per-SIMD wave sequencer: accepts a dispatched wave, builds its lane mask and
// thread base, runs the fetch/issue loop until RET, then pulses simd_done.
module simd_wave_ctrl #(
  parameter int                    WAVE_SIZE   = 32,
  parameter int                    PC_WIDTH    = 8,
  parameter int                    INSTR_WIDTH = 16,
  parameter logic [3:0]            OPC_RET     = 4'hF,
  parameter logic [PC_WIDTH-1:0]   START_PC    = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     simd_start,
  input  logic signed [31:0]       wave_id,
  input  logic signed [31:0]       core_block_id,
  input  logic [31:0]              block_dim,
  input  logic [31:0]              num_threads,
  output logic                     simd_done,
  output logic                     busy,
  output logic                     imem_req,
  output logic [PC_WIDTH-1:0]      imem_addr,
  input  logic                     imem_valid,
  input  logic [INSTR_WIDTH-1:0]   imem_data,
  output logic                     lane_issue,
  output logic [INSTR_WIDTH-1:0]   lane_instr,
  output logic [WAVE_SIZE-1:0]     lane_mask,
  output logic [31:0]              lane_thread_base,
  input  logic                     lane_done,
  output logic [2:0]               state_dbg
);

  // Handshakes: imem_req stays high with a stable imem_addr until imem_valid is
  // sampled high; lane_issue is a single-cycle pulse, after which the block waits
  // for lane_done (sampled only in WAIT_LANES) before fetching the next pc.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_ISSUE      = 3'd2,
    S_WAIT_LANES = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t                   state, state_n;
  logic [PC_WIDTH-1:0]      pc, pc_n;
  logic [INSTR_WIDTH-1:0]   instr_n;
  logic [WAVE_SIZE-1:0]     mask_n, mask_calc;
  logic [31:0]              base_n, base_calc, wave_off;

  assign state_dbg = state;

  // All arithmetic is 32-bit and wraps, matching the dispatcher's thread numbering.
  always_comb begin
    wave_off  = $unsigned(wave_id) * 32'(WAVE_SIZE);
    base_calc = $unsigned(core_block_id) * block_dim + wave_off;
    mask_calc = '0;
    for (int i = 0; i < WAVE_SIZE; i++) begin
      mask_calc[i] = (wave_off + 32'(i) < block_dim) && (base_calc + 32'(i) < num_threads);
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = lane_instr;
    mask_n  = lane_mask;
    base_n  = lane_thread_base;
    case (state)
      S_IDLE: begin
        if (simd_start && !wave_id[31]) begin
          base_n  = base_calc;
          mask_n  = mask_calc;
          pc_n    = START_PC;
          state_n = (mask_calc == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_valid) begin
          instr_n = imem_data;
          state_n = (imem_data[INSTR_WIDTH-1 -: 4] == OPC_RET) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: state_n = S_WAIT_LANES;
      S_WAIT_LANES: begin
        if (lane_done) begin
          pc_n    = pc + PC_WIDTH'(1);
          state_n = S_FETCH;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      pc               <= START_PC;
      simd_done        <= 1'b0;
      busy             <= 1'b0;
      imem_req         <= 1'b0;
      imem_addr        <= '0;
      lane_issue       <= 1'b0;
      lane_instr       <= '0;
      lane_mask        <= '0;
      lane_thread_base <= '0;
    end else begin
      state            <= state_n;
      pc               <= pc_n;
      simd_done        <= (state == S_DONE);
      busy             <= (state_n != S_IDLE);
      imem_req         <= (state_n == S_FETCH);
      imem_addr        <= pc_n;
      lane_issue       <= (state_n == S_ISSUE);
      lane_instr       <= instr_n;
      lane_mask        <= mask_n;
      lane_thread_base <= base_n;
    end
  end

endmodule

// File: tb/tb_simd_wave_ctrl.sv
// Bench for simd_wave_ctrl: table of wave vectors plus random waves, with the
// bench acting as instruction memory and lane datapath.
module tb_simd_wave_ctrl;
  localparam int PW = 8;
  localparam int IW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              simd_start = 1'b0;
  logic signed [31:0] wave_id = '0;
  logic signed [31:0] core_block_id = '0;
  logic [31:0]       block_dim = '0;
  logic [31:0]       num_threads = '0;
  logic              simd_done, busy, imem_req, lane_issue;
  logic [PW-1:0]     imem_addr;
  logic              imem_valid = 1'b0;
  logic [IW-1:0]     imem_data = '0;
  logic [IW-1:0]     lane_instr;
  logic [31:0]       lane_mask, lane_thread_base;
  logic              lane_done = 1'b0;
  logic [2:0]        state_dbg;

  always #5 clk = ~clk;

  simd_wave_ctrl dut (
    .clk(clk), .rst_n(rst_n), .simd_start(simd_start), .wave_id(wave_id),
    .core_block_id(core_block_id), .block_dim(block_dim), .num_threads(num_threads),
    .simd_done(simd_done), .busy(busy), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .lane_issue(lane_issue),
    .lane_instr(lane_instr), .lane_mask(lane_mask), .lane_thread_base(lane_thread_base),
    .lane_done(lane_done), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] prog [256];

  typedef struct {
    int          blk;
    int          wid;
    logic [31:0] bdim;
    logic [31:0] nthr;
    int          k;       // non-RET instructions before the RET
    int          df;      // cycles of imem wait before valid
    int          dl;      // WAIT_LANES cycles before lane_done
    bit          noise;   // lane_done high in ISSUE / random when don't-care
    bit          inject;  // stray simd_start during WAIT_LANES
    bit          abort_w; // async reset in WAIT_LANES
    logic [31:0] exp_base;
    logic [31:0] exp_mask;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int blk, input int wid, input logic [31:0] bdim,
                              input logic [31:0] nthr, input int k, input int df, input int dl,
                              input bit noise, input bit inject, input bit abort_w,
                              input logic [31:0] eb, input logic [31:0] em);
    vec_t v;
    v.blk = blk; v.wid = wid; v.bdim = bdim; v.nthr = nthr; v.k = k; v.df = df; v.dl = dl;
    v.noise = noise; v.inject = inject; v.abort_w = abort_w; v.exp_base = eb; v.exp_mask = em;
    return v;
  endfunction

  // Active lanes form a prefix: count = min(lanes left in block, threads left in kernel), clamped.
  function automatic logic [31:0] model_mask(input longint blk, input longint wid,
                                             input longint bdim, input longint nthr);
    longint base, n;
    logic [63:0] m;
    base = blk * bdim + wid * 32;
    n = bdim - wid * 32;
    if (nthr - base < n) n = nthr - base;
    if (n < 0) n = 0;
    if (n > 32) n = 32;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_simd_done"}, 64'(simd_done), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_imem_req"}, 64'(imem_req), 64'd0);
    check({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
    check({tag, "_lane_issue"}, 64'(lane_issue), 64'd0);
    check({tag, "_lane_instr"}, 64'(lane_instr), 64'd0);
    check({tag, "_lane_mask"}, 64'(lane_mask), 64'd0);
    check({tag, "_thread_base"}, 64'(lane_thread_base), 64'd0);
  endtask

  task automatic run_wave(input vec_t v);
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] act_q[$];
    int edges = 0, fcnt = 0, lcnt = 0, issue_cnt = 0, req_cycles = 0;
    int exp_lat, act_lat = -1;
    bit waiting = 0, injected = 0, aborted = 0;
    for (int i = 0; i < v.k; i++) prog[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    prog[v.k] = {4'hF, 12'($urandom)};
    if (v.exp_mask != 0) for (int i = 0; i <= v.k; i++) exp_q.push_back(PW'(i));
    exp_lat = (v.exp_mask == 0) ? 2 : 3 + v.k * (v.df + v.dl + 3) + v.df;

    @(negedge clk);
    simd_start = 1'b1; wave_id = v.wid; core_block_id = v.blk;
    block_dim = v.bdim; num_threads = v.nthr;
    while (act_lat < 0 && edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      simd_start = 1'b0;
      if (edges == 1) begin
        check("thread_base", 64'(lane_thread_base), 64'(v.exp_base));
        check("lane_mask", 64'(lane_mask), 64'(v.exp_mask));
        check("busy_after_start", 64'(busy), 64'd1);
      end
      if (simd_done) begin
        act_lat = edges;
        check("busy_drop_with_done", 64'(busy), 64'd0);
      end
      if (lane_issue) begin
        check("issue_instr", 64'(lane_instr), 64'(prog[issue_cnt % 256]));
        issue_cnt++;
        waiting = 1; lcnt = 0;
        lane_done = v.noise;
      end else if (waiting) begin
        if (v.abort_w) begin
          #2 rst_n = 1'b0;
          #1 check_all_zero("abort");
          aborted = 1;
          break;
        end
        if (v.inject && !injected) begin
          simd_start = 1'b1; wave_id = 5; core_block_id = 7; injected = 1;
        end
        if (lcnt == v.dl) begin lane_done = 1'b1; waiting = 0; end
        else begin lane_done = 1'b0; lcnt++; end
      end else begin
        lane_done = v.noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (imem_req) begin
        req_cycles++;
        if (fcnt == v.df) begin
          imem_valid = 1'b1; imem_data = prog[imem_addr]; act_q.push_back(imem_addr);
        end else begin
          imem_valid = 1'b0; imem_data = IW'($urandom); fcnt++;
        end
      end else begin
        imem_valid = 1'b0; imem_data = IW'($urandom); fcnt = 0;
      end
    end
    imem_valid = 1'b0; lane_done = 1'b0;

    if (aborted) begin
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("post_abort_no_done", 64'({simd_done, busy}), 64'd0);
      end
      return;
    end

    check("done_latency", 64'(act_lat), 64'(exp_lat));
    check("issue_count", 64'(issue_cnt), 64'(v.k * (v.exp_mask != 0 ? 1 : 0)));
    check("fetch_count", 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      check("fetch_addr", 64'(act_q[i]), 64'(exp_q[i]));
    if (v.exp_mask == 0) check("empty_no_req", 64'(req_cycles), 64'd0);
    check("base_held", 64'(lane_thread_base), 64'(v.exp_base));
    @(negedge clk);
    check("done_single_pulse", 64'({simd_done, busy}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    vec_t rv;
    tbl[0]  = mk(1, 1, 64, 128, 0, 0, 0, 0, 0, 0, 32'd96, 32'hFFFF_FFFF);
    tbl[1]  = mk(1, 1, 64, 100, 1, 1, 0, 0, 0, 0, 32'd96, 32'h0000_000F);
    tbl[2]  = mk(0, 0, 64, 128, 2, 2, 3, 0, 0, 0, 32'd0, 32'hFFFF_FFFF);
    tbl[3]  = mk(1, 1, 64, 96, 2, 0, 0, 0, 0, 0, 32'd96, 32'h0);
    tbl[4]  = mk(0, 1, 40, 1000, 1, 0, 1, 0, 0, 0, 32'd32, 32'h0000_00FF);
    tbl[5]  = mk(2, 1, 48, 140, 3, 1, 2, 0, 0, 0, 32'd128, 32'h0000_0FFF);
    tbl[6]  = mk(3, 1, 16, 1000, 1, 0, 0, 0, 0, 0, 32'd80, 32'h0);
    tbl[7]  = mk(0, 0, 64, 128, 2, 1, 2, 1, 1, 0, 32'd0, 32'hFFFF_FFFF);
    tbl[8]  = mk(1, 0, 64, 128, 3, 0, 5, 0, 0, 1, 32'd64, 32'hFFFF_FFFF);
    tbl[9]  = mk(0, 0, 64, 128, 1, 0, 0, 0, 0, 0, 32'd0, 32'hFFFF_FFFF);
    tbl[10] = mk(-1, 1, 64, 32'hFFFF_FFF0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFE0, 32'h0000_FFFF);

    #12 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 11; t++) run_wave(tbl[t]);

    // Invalid wave id is ignored in IDLE.
    @(negedge clk);
    simd_start = 1'b1; wave_id = -1; core_block_id = 0; block_dim = 64; num_threads = 128;
    @(negedge clk);
    simd_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("neg_wave_idle", 64'({busy, imem_req, simd_done}), 64'd0);
      @(negedge clk);
    end

    for (int r = 0; r < 12; r++) begin
      int blk, wid, bdim, nthr;
      blk = $urandom_range(0, 7); wid = $urandom_range(0, 7);
      bdim = $urandom_range(1, 200); nthr = $urandom_range(0, 2000);
      rv = mk(blk, wid, bdim, nthr, $urandom_range(0, 4), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
              32'(blk * bdim + wid * 32), model_mask(blk, wid, bdim, nthr));
      run_wave(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
